// File: rtl/miter_step_pkg.sv
// Shared definitions for the miter step controller: FSM state encoding and
// the default width of the cycle counter, depth and fail_cycle.
package miter_step_pkg;

  localparam int unsigned MITER_STEP_CW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } miter_step_state_e;

endpackage

// File: rtl/miter_fail_capture.sv
// First-fail latch: records the cycle index of the first sampled fail and
// ignores later ones until cleared.
import miter_step_pkg::*;

module miter_fail_capture #(
  parameter int unsigned CW = MITER_STEP_CW
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          sample,
  input  logic          fail,
  input  logic [CW-1:0] cycle,
  output logic          seen,
  output logic [CW-1:0] fail_cycle
);

  // Clear has priority so an aborted or restarted run never inherits a fail.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seen       <= 1'b0;
      fail_cycle <= '0;
    end else if (clear) begin
      seen       <= 1'b0;
      fail_cycle <= '0;
    end else if (sample && fail && !seen) begin
      seen       <= 1'b1;
      fail_cycle <= cycle;
    end
  end

endmodule

// File: rtl/miter_step_ctrl.sv
// Bounded equivalence-check sequencer: one INIT pulse, then depth miter steps,
// then a held pass/fail result with the first failing cycle.
// Optional build macro: MITER_STEP_STOP_ON_FAIL_EN ends the run at the first
// sampled fail instead of completing all depth steps.
import miter_step_pkg::*;

module miter_step_ctrl #(
  parameter int unsigned CW = MITER_STEP_CW
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] depth,
  input  logic          fail,
  output logic          init_en,
  output logic          step_en,
  output logic [CW-1:0] cycle,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] fail_cycle
);

  miter_step_state_e state, state_next;

  logic [CW-1:0] depth_q;
  logic [CW-1:0] depth_m1;
  logic          accept;
  logic          last_step;
  logic          seen;
  logic          in_run;

  assign in_run    = (state == RUN);
  assign accept    = start && !abort && ((state == IDLE) || (state == DONE));
  assign depth_m1  = depth_q - {{(CW-1){1'b0}}, 1'b1};
  assign last_step = (cycle == depth_m1);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic; abort overrides everything, including start.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) state_next = INIT;
        INIT:       state_next = (depth_q == '0) ? DONE : RUN;
        RUN: begin
`ifdef MITER_STEP_STOP_ON_FAIL_EN
          if (fail || last_step) state_next = DONE;
`else
          if (last_step) state_next = DONE;
`endif
        end
        default:    state_next = IDLE;
      endcase
    end
  end

  // Output decode; pass is only meaningful together with done.
  always_comb begin
    init_en = 1'b0;
    step_en = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    pass    = 1'b0;
    case (state)
      INIT: begin
        init_en = 1'b1;
        busy    = 1'b1;
      end
      RUN: begin
        step_en = 1'b1;
        busy    = 1'b1;
      end
      DONE: begin
        done = 1'b1;
        pass = !seen;
      end
      default: ;
    endcase
  end

  // Depth latch: captured only on an accepted start, dropped on abort.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    depth_q <= '0;
    else if (abort)  depth_q <= '0;
    else if (accept) depth_q <= depth;
  end

  // Step counter: advances only while the FSM stays in RUN, so it holds the
  // final (or stopping) step index through DONE and can never wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                           cycle <= '0;
    else if (abort || accept)               cycle <= '0;
    else if (in_run && state_next == RUN)   cycle <= cycle + {{(CW-1){1'b0}}, 1'b1};
  end

  miter_fail_capture #(.CW(CW)) u_fail_capture (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (abort || accept),
    .sample     (in_run),
    .fail       (fail),
    .cycle      (cycle),
    .seen       (seen),
    .fail_cycle (fail_cycle)
  );

endmodule

// File: tb/tb_miter_step_ctrl.sv
// Directed bench for miter_step_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are checked at the same point, i.e. after the edge
// has settled and well before the next one.
module tb_miter_step_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [31:0] depth;
  logic        fail;
  logic        init_en;
  logic        step_en;
  logic [31:0] cycle;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] fail_cycle;

  int unsigned errors = 0;
  int unsigned checks = 0;

  miter_step_ctrl #(.CW(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .depth      (depth),
    .fail       (fail),
    .init_en    (init_en),
    .step_en    (step_en),
    .cycle      (cycle),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_cycle (fail_cycle)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic ie, input logic se, input logic bz,
                      input logic dn, input logic ps, input logic [31:0] cy,
                      input logic [31:0] fc);
    chk({tag, ".init_en"},    {31'd0, init_en}, {31'd0, ie});
    chk({tag, ".step_en"},    {31'd0, step_en}, {31'd0, se});
    chk({tag, ".busy"},       {31'd0, busy},    {31'd0, bz});
    chk({tag, ".done"},       {31'd0, done},    {31'd0, dn});
    chk({tag, ".pass"},       {31'd0, pass},    {31'd0, ps});
    chk({tag, ".cycle"},      cycle,            cy);
    chk({tag, ".fail_cycle"}, fail_cycle,       fc);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; depth = '0; fail = 1'b0;
    #12;
    outs("reset", 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    tick();
    outs("idle", 0, 0, 0, 0, 0, 0, 0);

    // depth=3, no fail; depth input changes after acceptance are ignored
    depth = 32'd3; start = 1'b1;
    tick(); start = 1'b0; depth = 32'd9;
    outs("d3.init", 1, 0, 1, 0, 0, 0, 0);
    tick(); outs("d3.s0", 0, 1, 1, 0, 0, 0, 0);
    start = 1'b1;  // ignored while RUN
    tick(); start = 1'b0;
    outs("d3.s1", 0, 1, 1, 0, 0, 1, 0);
    tick(); outs("d3.s2", 0, 1, 1, 0, 0, 2, 0);
    tick(); outs("d3.done", 0, 0, 0, 1, 1, 2, 0);
    tick(); outs("d3.hold", 0, 0, 0, 1, 1, 2, 0);

    // depth=5, fail at cycle 2 and cycle 4; restart from DONE
    depth = 32'd5; start = 1'b1;
    tick(); start = 1'b0;
    outs("d5.init", 1, 0, 1, 0, 0, 0, 0);
    tick(); outs("d5.s0", 0, 1, 1, 0, 0, 0, 0);
    tick(); outs("d5.s1", 0, 1, 1, 0, 0, 1, 0);
    tick(); outs("d5.s2", 0, 1, 1, 0, 0, 2, 0);
    fail = 1'b1;
    tick(); fail = 1'b0;
`ifdef MITER_STEP_STOP_ON_FAIL_EN
    outs("d5.stop", 0, 0, 0, 1, 0, 2, 2);
    tick(); outs("d5.hold", 0, 0, 0, 1, 0, 2, 2);
`else
    outs("d5.s3", 0, 1, 1, 0, 0, 3, 2);
    tick(); outs("d5.s4", 0, 1, 1, 0, 0, 4, 2);
    fail = 1'b1;
    tick(); fail = 1'b0;
    outs("d5.done", 0, 0, 0, 1, 0, 4, 2);
`endif

    // depth=0: INIT only, then pass
    depth = 32'd0; start = 1'b1;
    tick(); start = 1'b0;
    outs("d0.init", 1, 0, 1, 0, 0, 0, 0);
    tick(); outs("d0.done", 0, 0, 0, 1, 1, 0, 0);

    // depth=8, abort together with start at cycle 3
    depth = 32'd8; start = 1'b1;
    tick(); start = 1'b0;
    outs("ab.init", 1, 0, 1, 0, 0, 0, 0);
    tick(); tick(); tick();
    outs("ab.s2", 0, 1, 1, 0, 0, 2, 0);
    fail = 1'b1;  // fail at cycle 2 must be discarded by the abort
    tick(); fail = 1'b0;
    outs("ab.s3", 0, 1, 1, 0, 0, 3, 2);
    abort = 1'b1; start = 1'b1;
    tick(); abort = 1'b0; start = 1'b0;
    outs("ab.idle", 0, 0, 0, 0, 0, 0, 0);
    tick(); outs("ab.idle2", 0, 0, 0, 0, 0, 0, 0);

    // back-to-back: run 1 fails at cycle 1, run 2 depth=2 clean
    depth = 32'd4; start = 1'b1;
    tick(); start = 1'b0;
    outs("bb1.init", 1, 0, 1, 0, 0, 0, 0);
    tick(); tick();
    outs("bb1.s1", 0, 1, 1, 0, 0, 1, 0);
    fail = 1'b1;
    tick(); fail = 1'b0;
`ifdef MITER_STEP_STOP_ON_FAIL_EN
    outs("bb1.done", 0, 0, 0, 1, 0, 1, 1);
`else
    outs("bb1.s2", 0, 1, 1, 0, 0, 2, 1);
    tick(); outs("bb1.s3", 0, 1, 1, 0, 0, 3, 1);
    tick(); outs("bb1.done", 0, 0, 0, 1, 0, 3, 1);
`endif
    depth = 32'd2; start = 1'b1;
    tick(); start = 1'b0;
    outs("bb2.init", 1, 0, 1, 0, 0, 0, 0);
    tick(); outs("bb2.s0", 0, 1, 1, 0, 0, 0, 0);
    tick(); outs("bb2.s1", 0, 1, 1, 0, 0, 1, 0);
    tick(); outs("bb2.done", 0, 0, 0, 1, 1, 1, 0);

    // asynchronous reset mid-run at cycle 4, then a normal depth=1 run
    depth = 32'd8; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    outs("rs.s3", 0, 1, 1, 0, 0, 3, 0);
    fail = 1'b1;
    tick(); fail = 1'b0;
    outs("rs.s4", 0, 1, 1, 0, 0, 4, 3);
    #2 reset_n = 1'b0;
    #1 outs("rs.async", 0, 0, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b1;
    tick(); outs("rs.idle", 0, 0, 0, 0, 0, 0, 0);
    depth = 32'd1; start = 1'b1;
    tick(); start = 1'b0;
    outs("rs.init", 1, 0, 1, 0, 0, 0, 0);
    tick(); outs("rs.s0", 0, 1, 1, 0, 0, 0, 0);
    tick(); outs("rs.done", 0, 0, 0, 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
